// File: rtl/channel_scan_sequencer_if.sv
// Request/dwell inputs and decoder-facing outputs of the channel scan sequencer.
// The sequencer takes the slave side and the requester/decoder harness takes the master side.
interface channel_scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic [3:0]         req;
    logic [DWELL_W-1:0] dwell;
    logic               a0;
    logic               a1;
    logic               enable;
    logic               done;
    logic               busy;

    modport master (
        output req,
        output dwell,
        input  a0,
        input  a1,
        input  enable,
        input  done,
        input  busy
    );

    modport slave (
        input  req,
        input  dwell,
        output a0,
        output a1,
        output enable,
        output done,
        output busy
    );
endinterface

// File: rtl/channel_scan_sequencer.sv
// Round-robin grant sequencer that feeds the 2-to-4 decoder.
// Each grant lasts a fixed dwell, and one dead cycle separates any two grants.
module channel_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    channel_scan_sequencer_if.slave  io_bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_last;
    logic [1:0]         w_last_next;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_next;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_next;
    logic               r_done;
    logic               w_done_next;
    logic               r_enable;
    logic               r_busy;

    logic [1:0]         w_cand [4];
    logic [3:0]         w_rot;
    logic [1:0]         w_winner;
    logic               w_any_req;
    logic               w_granted_req;

    // w_rot[0] is the channel right after the last grant, so it has the highest priority.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rotate
            assign w_cand[gi] = r_last + 2'(gi + 1);
            assign w_rot[gi]  = io_bus.req[w_cand[gi]];
        end
    endgenerate

    assign w_any_req     = |io_bus.req;
    assign w_granted_req = io_bus.req[r_idx];

    always_comb begin
        w_winner = w_cand[3];
        if (w_rot[0]) begin
            w_winner = w_cand[0];
        end else if (w_rot[1]) begin
            w_winner = w_cand[1];
        end else if (w_rot[2]) begin
            w_winner = w_cand[2];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE, S_GAP: begin
                if (w_any_req) begin
                    w_state_next = S_GRANT;
                    w_idx_next   = w_winner;
                    w_last_next  = w_winner;
                    w_cnt_next   = io_bus.dwell;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_GRANT: begin
                // A dropped request takes priority over a dwell that is just completing.
                if (!w_granted_req) begin
                    w_state_next = S_GAP;
                end else if (r_cnt == '0) begin
                    w_state_next = S_GAP;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - DWELL_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ENABLE and BUSY come from the next state so that every decoder input is a flop output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_last   <= 2'd3;
            r_idx    <= 2'd0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_last   <= w_last_next;
            r_idx    <= w_idx_next;
            r_cnt    <= w_cnt_next;
            r_done   <= w_done_next;
            r_enable <= (w_state_next == S_GRANT);
            r_busy   <= (w_state_next != S_IDLE);
        end
    end

    assign io_bus.a0     = r_idx[1];
    assign io_bus.a1     = r_idx[0];
    assign io_bus.enable = r_enable;
    assign io_bus.done   = r_done;
    assign io_bus.busy   = r_busy;

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// Bench for channel_scan_sequencer: directed scenarios from the test plan plus
// randomized traffic compared against a grant/gap reference model.
module tb_channel_scan_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    channel_scan_sequencer_if #(.DWELL_W(8)) bus ();

    channel_scan_sequencer #(.DWELL_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    logic [4:0] obs;
    assign obs = {bus.a0, bus.a1, bus.enable, bus.done, bus.busy};

    // Reference model. m_phase: 0 idle, 1 granting, 2 gap.
    // m_left is the number of grant cycles still owed, counting the current one.
    int   m_phase;
    int   m_ch;
    int   m_left;
    int   m_last;
    logic m_done;

    function automatic int pick(logic [3:0] r, int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function void model_reset();
        m_phase = 0;
        m_ch    = 0;
        m_last  = 3;
        m_left  = 0;
        m_done  = 1'b0;
    endfunction

    function void model_step(logic [3:0] r, logic [7:0] d);
        int c;
        m_done = 1'b0;
        if (m_phase == 1) begin
            if (!r[m_ch]) begin
                m_phase = 2;
            end else if (m_left == 1) begin
                m_phase = 2;
                m_done  = 1'b1;
            end else begin
                m_left = m_left - 1;
            end
        end else begin
            c = pick(r, m_last);
            if (c >= 0) begin
                m_phase = 1;
                m_ch    = c;
                m_last  = c;
                m_left  = int'(d) + 1;
            end else begin
                m_phase = 0;
            end
        end
    endfunction

    function logic [4:0] model_out();
        logic [1:0] ch;
        ch = 2'(m_ch);
        return {ch, (m_phase == 1), m_done, (m_phase != 0)};
    endfunction

    task automatic tick(input logic [3:0] r, input logic [7:0] d);
        bus.req   = r;
        bus.dwell = d;
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    task automatic do_reset();
        bus.req   = 4'b0000;
        bus.dwell = 8'd0;
        rst_n     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL reset_release got=%b want=%b", obs, 5'b00000);
        end
        for (int i = 0; i < 5; i++) begin
            tick(4'b0000, 8'd0);
            checks++;
            if (obs !== 5'b00000) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got=%b want=%b", i, obs, 5'b00000);
            end
        end
    endtask

    task automatic test_single_channel();
        logic [4:0] want [6];
        want = '{5'b10101, 5'b10101, 5'b10101, 5'b10101, 5'b10011, 5'b10101};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(4'b0100, 8'd3);
            checks++;
            if (obs !== want[i]) begin
                failures++;
                $display("FAIL single_ch2 cycle=%0d got=%b want=%b", i, obs, want[i]);
            end
            checks++;
            if (obs !== model_out()) begin
                failures++;
                $display("FAIL single_ch2_model cycle=%0d got=%b want=%b", i, obs, model_out());
            end
        end
    endtask

    task automatic test_rotate();
        logic [1:0] ix;
        logic [4:0] want;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(4'b1111, 8'd0);
            ix   = 2'((i / 2) % 4);
            want = (i % 2 == 0) ? {ix, 3'b101} : {ix, 3'b011};
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL rotate cycle=%0d got=%b want=%b", i, obs, want);
            end
        end
    endtask

    task automatic test_abort();
        logic [4:0] want_tail [3];
        want_tail = '{5'b01001, 5'b01000, 5'b01000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(4'b0010, 8'd10);
            checks++;
            if (obs !== 5'b01101) begin
                failures++;
                $display("FAIL abort_grant cycle=%0d got=%b want=%b", i, obs, 5'b01101);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(4'b0000, 8'd10);
            checks++;
            if (obs !== want_tail[i]) begin
                failures++;
                $display("FAIL abort_tail cycle=%0d got=%b want=%b", i, obs, want_tail[i]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        tick(4'b1000, 8'd5);
        tick(4'b1000, 8'd5);
        checks++;
        if (obs !== 5'b11101) begin
            failures++;
            $display("FAIL mid_grant_pre got=%b want=%b", obs, 5'b11101);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL async_reset got=%b want=%b", obs, 5'b00000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL reset_held got=%b want=%b", obs, 5'b00000);
        end
        rst_n = 1'b1;
        model_reset();
        tick(4'b1000, 8'd5);
        checks++;
        if (obs !== 5'b11101) begin
            failures++;
            $display("FAIL regrant_after_reset got=%b want=%b", obs, 5'b11101);
        end
    endtask

    task automatic test_dwell_change();
        logic want_en;
        logic want_done;
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            tick(4'b0001, (c == 1) ? 8'd2 : 8'd7);
            want_en   = (c <= 3) || (c >= 5 && c <= 12);
            want_done = (c == 4) || (c == 13);
            checks++;
            if (bus.enable !== want_en || bus.done !== want_done) begin
                failures++;
                $display("FAIL dwell_change cycle=%0d got_en=%b got_done=%b want_en=%b want_done=%b",
                         c, bus.enable, bus.done, want_en, want_done);
            end
        end
    endtask

    task automatic test_max_dwell();
        int n;
        do_reset();
        n = 0;
        tick(4'b0001, 8'hFF);
        while (bus.enable === 1'b1 && n < 300) begin
            n++;
            tick(4'b0001, 8'hFF);
        end
        checks++;
        if (n != 256 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL max_dwell got_len=%0d got_done=%b want_len=256 want_done=1", n, bus.done);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [7:0] d;
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            d = 8'($urandom_range(0, 4));
            tick(r, d);
            checks++;
            if (obs !== model_out()) begin
                failures++;
                $display("FAIL random cycle=%0d req=%b got=%b want=%b", i, r, obs, model_out());
            end
        end
    endtask

    initial begin
        bus.req   = 4'b0000;
        bus.dwell = 8'd0;
        model_reset();
        #1;
        test_reset();
        test_single_channel();
        test_rotate();
        test_abort();
        test_reset_mid_grant();
        test_dwell_change();
        test_max_dwell();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/channel_scan_sequencer.md
# channel_scan_sequencer

Registered round-robin sequencer that sits directly upstream of the 2-to-4 decoder and drives its A0, A1 and ENABLE inputs. It arbitrates four request lines and grants one channel at a time for a programmable dwell period. It inserts a one-cycle break-before-make gap between grants and pulses DONE when a grant completes. All outputs are registered, so the decoder sees glitch-free select and enable.

## Interface
- DWELL_W, default 8: width of the dwell counter and of the DWELL input.

- CLK  input  1  single clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- REQ  input  4  request per channel; REQ[n] requests channel n.
- DWELL  input  DWELL_W  grant length minus one, in cycles; sampled at grant start.
- A0  output  1  channel index MSB to the decoder.
- A1  output  1  channel index LSB to the decoder; granted channel n = 2*A0 + A1.
- ENABLE  output  1  high while a channel is granted.
- DONE  output  1  one-cycle pulse in the cycle after a grant completes its full dwell.
- BUSY  output  1  high in GRANT and GAP states.

## Operation
- The FSM has three states:
  - IDLE: ENABLE=0, BUSY=0.
  - GRANT: ENABLE=1, BUSY=1.
  - GAP: ENABLE=0, BUSY=1.
- Internal state:
  - LAST: 2-bit pointer to the last granted channel.
  - CNT: DWELL_W-bit down-counter.
- Arbitration is combinational on REQ and LAST.
  - Search order is LAST+1, LAST+2, LAST+3, LAST, all mod 4.
  - The first asserted request wins.
- IDLE:
  - If any REQ bit is set: load {A0,A1} with the winner, LAST with the winner, and CNT with DWELL. Go to GRANT.
  - Otherwise remain in IDLE.
- GRANT:
  - If REQ of the granted channel is low: abort. Go to GAP with no DONE pulse.
  - Else if CNT==0: go to GAP and assert DONE for the next cycle.
  - Else decrement CNT.
- GAP:
  - Lasts exactly one cycle.
  - If any REQ bit is set, arbitrate and load as in IDLE, then go to GRANT.
  - Otherwise go to IDLE.
- A0 and A1 change only on entry to GRANT. They hold their value in GAP and IDLE, so the decoder never sees an index change while ENABLE=1.
- A channel requesting continuously alone is regranted after each one-cycle gap.
- When REQ=4'b1111, grants rotate 0,1,2,3,0,...
- A DWELL change during a grant has no effect until the next grant start.
- Reset values: state=IDLE, A0=0, A1=0, ENABLE=0, DONE=0, BUSY=0, CNT=0, LAST=3, so the first search starts at channel 0.
- Reset mid-grant: all outputs return to reset values immediately (asynchronously). The first grant after release re-arbitrates from channel 0.

## Timing
- Latency: REQ sampled high in IDLE at edge k gives ENABLE=1 and a valid index after edge k.
- A full grant holds ENABLE high for exactly DWELL+1 cycles.
  - DWELL=0 gives a 1-cycle grant.
  - DWELL = all-ones gives 2^DWELL_W cycles; there is no wrap, since CNT stops at 0.
- DONE is high in the single GAP cycle that follows a completed grant. It is never high after an abort.
- ENABLE is low for at least one cycle between any two grants.
- Back-to-back grant period with continuous requests is DWELL+2 cycles.
- Abort: REQ of the granted channel sampled low at edge k gives ENABLE=0 after edge k.
- Simultaneous abort and CNT==0 in the same cycle: the abort takes priority, so DONE stays 0.

## Test plan
- Reset release with REQ=0 for 5 cycles: A0=A1=ENABLE=DONE=BUSY=0 throughout.
- REQ=4'b0100, DWELL=3:
  - One cycle after the request, {A0,A1}=2'b10 and ENABLE=1 for 4 cycles.
  - Then ENABLE=0 and DONE=1 for 1 cycle.
  - Then a regrant of channel 2.
- REQ=4'b1111, DWELL=0: the index sequence is 0,1,2,3,0, with ENABLE toggling 1,0 every cycle and a DONE pulse in every gap.
- REQ=4'b0010, DWELL=10, REQ dropped to 0 on the 3rd grant cycle: ENABLE falls on the next cycle, DONE stays 0, and the FSM returns to IDLE after one gap cycle.
- RESET_N pulsed low mid-grant on channel 3: ENABLE, A0 and A1 go to 0 without waiting for a clock edge. After release with REQ=4'b1000, channel 3 is granted again after 1 cycle.
- DWELL changed from 2 to 7 during a grant: the current grant is still 3 cycles long and the next grant is 8 cycles long.
